hw_input_stencil_load_ctrl: RTL and testbench

HW_INPUT_STENCIL_LOAD_CTRL -- requirements
Module: hw_input_stencil_load_ctrl

---
 rtl/hw_input_stencil_load_ctrl.sv | 91 +++++++++
 tb/tb_hw_input_stencil_load_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hw_input_stencil_load_ctrl.sv
// Streams one IMG_W x IMG_H frame from a valid/ready pixel source into the
// hw_input stencil buffer, one registered write per accepted pixel, then holds it.
module hw_input_stencil_load_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        op_hcompute_hw_input_stencil_write_wen,
  output logic [15:0] op_hcompute_hw_input_stencil_write_ctrl_vars [3],
  output logic [15:0] op_hcompute_hw_input_stencil_write [1],
  output logic        frame_loaded,
  input  logic        buf_release,
  output logic        busy
);

  localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;

  state_t      state;
  logic [15:0] x;
  logic [15:0] y;
  logic        wen;
  logic [15:0] wr_y;
  logic [15:0] wr_x;
  logic [15:0] wr_data;
  logic        accept;

  assign accept = in_valid && (state == LOAD);

  // NOTE: all state below updates with <= so every register samples pre-edge
  // values; the write stage captures (y, x) before the counters advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      wen     <= 1'b0;
      wr_y    <= '0;
      wr_x    <= '0;
      wr_data <= '0;
    end else begin
      wen <= accept;
      if (accept) begin
        wr_y    <= y;
        wr_x    <= x;
        wr_data <= in_data;
      end

      unique case (state)
        IDLE:  if (start) state <= LOAD;
        LOAD: begin
          if (accept) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y     <= '0;
                state <= FLUSH;
              end else begin
                y <= y + 16'd1;
              end
            end else begin
              x <= x + 16'd1;
            end
          end
        end
        // The last pixel's write is on the port during this single cycle.
        FLUSH: state <= HOLD;
        HOLD:  if (buf_release) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == LOAD);
  assign busy         = (state == LOAD) || (state == FLUSH);
  assign frame_loaded = (state == HOLD);

  assign op_hcompute_hw_input_stencil_write_wen          = wen;
  assign op_hcompute_hw_input_stencil_write_ctrl_vars[0] = 16'd0;
  assign op_hcompute_hw_input_stencil_write_ctrl_vars[1] = wr_y;
  assign op_hcompute_hw_input_stencil_write_ctrl_vars[2] = wr_x;
  assign op_hcompute_hw_input_stencil_write[0]           = wr_data;

endmodule

// File: tb/tb_hw_input_stencil_load_ctrl.sv
// Directed sequence with random stalls/data; every write is checked against
// the raster order (beat k -> y = k / W, x = k % W) and the beat's own data.
module tb_hw_input_stencil_load_ctrl;

  localparam int W = 64;
  localparam int H = 64;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        buf_release = 1'b0;
  logic        in_ready;
  logic        wen;
  logic [15:0] cv [3];
  logic [15:0] wd [1];
  logic        frame_loaded;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] last_y = '0;
  logic [15:0] last_x = '0;
  logic [15:0] last_d = '0;

  hw_input_stencil_load_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk                                         (clk),
    .rst                                         (rst),
    .start                                       (start),
    .in_valid                                    (in_valid),
    .in_data                                     (in_data),
    .in_ready                                    (in_ready),
    .op_hcompute_hw_input_stencil_write_wen      (wen),
    .op_hcompute_hw_input_stencil_write_ctrl_vars(cv),
    .op_hcompute_hw_input_stencil_write          (wd),
    .frame_loaded                                (frame_loaded),
    .buf_release                                 (buf_release),
    .busy                                        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write_port(input string tag);
    check({tag, "_root"}, cv[0], 0);
    check({tag, "_y"}, cv[1], last_y);
    check({tag, "_x"}, cv[2], last_x);
    check({tag, "_data"}, wd[0], last_d);
  endtask

  // Streams n_beats pixels (gap_pct% idle cycles). raster selects data = y*64+x;
  // poke injects start/buf_release pulses that LOAD must ignore.
  task automatic run_load(input int n_beats, input int gap_pct, input bit raster, input bit poke);
    int k = 0;
    int cyc = 0;
    bit v;
    logic [15:0] d;
    start = 1'b1;
    step();
    start = 1'b0;
    check("enter_ready", in_ready, 1);
    check("enter_busy", busy, 1);
    check("enter_wen", wen, 0);
    while (k < n_beats && cyc < 8 * N) begin
      v = ($urandom_range(99) >= gap_pct);
      d = raster ? 16'((k / W) * 64 + (k % W)) : 16'($urandom);
      in_valid    = v;
      in_data     = d;
      start       = poke && (cyc % 97 == 50);
      buf_release = poke && (cyc % 89 == 40);
      step();
      cyc++;
      check("wen", wen, 32'(v));
      if (v) begin
        last_y = 16'(k / W);
        last_x = 16'(k % W);
        last_d = d;
        if (k == 63) check("wrap_x63", cv[2], 63);
        if (k == 64) check("wrap_y1", cv[1], 1);
        k++;
      end
      check_write_port("write");
      check("in_ready", in_ready, 32'(k < N));
      check("busy_load", busy, 1);
      check("loaded_low", frame_loaded, 0);
    end
    in_valid    = 1'b0;
    start       = 1'b0;
    buf_release = 1'b0;
    if (k < n_beats) check("load_timeout", k, n_beats);
  endtask

  // Called right after the FLUSH cycle has been observed.
  task automatic finish_frame();
    step();
    check("hold_loaded", frame_loaded, 1);
    check("hold_wen", wen, 0);
    check("hold_busy", busy, 0);
    check("hold_ready", in_ready, 0);
    check_write_port("hold_keep");
    start = 1'b1;
    step();
    start = 1'b0;
    check("hold_start_loaded", frame_loaded, 1);
    check("hold_start_ready", in_ready, 0);
    check("hold_start_busy", busy, 0);
    buf_release = 1'b1;
    step();
    buf_release = 1'b0;
    check("release_loaded", frame_loaded, 0);
    check("release_busy", busy, 0);
    check("release_ready", in_ready, 0);
    step();
    check("idle_stays", in_ready, 0);
  endtask

  initial begin
    // Reset wins over every other request.
    start = 1'b1; in_valid = 1'b1; buf_release = 1'b1; in_data = 16'hbeef;
    step();
    step();
    check("rst_ready", in_ready, 0);
    check("rst_wen", wen, 0);
    check("rst_loaded", frame_loaded, 0);
    check("rst_busy", busy, 0);
    check_write_port("rst");
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; buf_release = 1'b0;
    step();
    check("post_rst_idle", busy, 0);

    run_load(N, 0, 1'b1, 1'b0);
    finish_frame();

    run_load(N, 50, 1'b1, 1'b1);
    finish_frame();

    // Abandon a frame after 100 beats with a beat in flight.
    run_load(100, 0, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; start = 1'b1;
    step();
    last_y = '0; last_x = '0; last_d = '0;
    check("midrst_wen", wen, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check_write_port("midrst");
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    step();
    check("midrst_wen2", wen, 0);
    check("midrst_idle", busy, 0);

    run_load(N, 30, 1'b0, 1'b0);
    finish_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
